vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
Shares one single-port frame-buffer RAM between the display refresh path and a pixel-write requester. The display path is driven by disp_ena/col/row from the VGA timing generator. Display reads have absolute priority during the active region. Host writes and a hardware frame-clear sequence use blanking cycles only. Sits between the VGA timing generator, the frame-buffer RAM and the drawing/host logic.

Parameters:
H_PIXELS, 50, visible columns per line
V_PIXELS, 25, visible rows per frame
H_BITS, 7, col width
V_BITS, 5, row width
DATA_W, 4, pixel width
ADDR_W, 11, RAM address width (must cover H_PIXELS*V_PIXELS = 1250)
CLEAR_VALUE, 0, pixel value written by the clear sequence

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
disp_ena  in  1  timing generator: active display region
col  in  H_BITS  timing generator: current column
row  in  V_BITS  timing generator: current row
wr_valid  in  1  write request valid
wr_ready  out  1  write accepted this cycle
wr_col  in  H_BITS  write column
wr_row  in  V_BITS  write row
wr_data  in  DATA_W  write pixel
clear_req  in  1  start full-frame clear (pulse)
busy  out  1  clear sequence in progress
clear_done  out  1  one-cycle pulse when clear completes
wr_err  out  1  sticky: out-of-range write seen
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
pix_valid  out  1  pixel output valid
pix_data  out  DATA_W  pixel to DAC

Behaviour:
- Address mapping: addr = row*H_PIXELS + col, computed at ADDR_W bits with no truncation for in-range coordinates.
- Reset: state IDLE, clear address 0. pix_valid, pix_data, busy, clear_done and wr_err are all 0. A display read pending in the pipeline is discarded.
- The mem_* outputs and wr_ready are combinational from current inputs and state. wr_ready is 0 while rst=1.
- Priority order each cycle: display read > clear write > host write.
- Display read: when disp_ena=1 in cycle t, drive mem_en=1, mem_we=0, mem_addr from col/row. RAM data returns in t+1 and is registered. pix_valid=1 and pix_data=mem_rdata in cycle t+2. Otherwise pix_valid=0 and pix_data holds its last value.
- States: IDLE and CLEAR.
- IDLE:
  - wr_ready = !disp_ena.
  - On transfer (wr_valid && wr_ready), if wr_col<H_PIXELS and wr_row<V_PIXELS: mem_en=1, mem_we=1, mem_wdata=wr_data.
  - If the coordinates are out of range, the write is accepted and dropped (no mem_we) and wr_err is set. wr_err clears only on rst.
  - clear_req=1 moves to CLEAR with clear address 0. In that same cycle a host transfer is still honoured.
- CLEAR:
  - busy=1 and wr_ready=0.
  - Each cycle with disp_ena=0: mem_en=1, mem_we=1, mem_addr=clear address, mem_wdata=CLEAR_VALUE; clear address increments.
  - Cycles with disp_ena=1 pause the clear without advancing the address.
  - After the write to address H_PIXELS*V_PIXELS-1: return to IDLE and pulse clear_done for one cycle; busy drops the same cycle.
  - clear_req while in CLEAR is ignored.
- Display reads continue during CLEAR and may show a partially cleared frame.
- Reset mid-clear: abort the clear, no clear_done, state IDLE.
- wr_valid held while wr_ready=0: the request stays pending. The requester must hold its address and data stable until the transfer.

Decomposition:
- Shared package vga_pkg: H_PIXELS, V_PIXELS, H_BITS, V_BITS, DATA_W, ADDR_W, the fb_state_t enum (IDLE, CLEAR), and the address-mapping function.
- One sub-module is natural: vga_fb_readpipe, the 2-stage display read pipeline producing pix_valid/pix_data.

Test Plan:
- Reset, then disp_ena=1, col=3, row=2 -> mem_addr=103, mem_we=0. With mem_rdata=0xA in the next cycle, pix_valid=1 and pix_data=0xA two cycles after the request.
- wr_valid=1, wr_col=49, wr_row=24, wr_data=5, disp_ena=0 -> wr_ready=1, mem_we=1, mem_addr=1249, mem_wdata=5.
- The same write held while disp_ena=1 -> wr_ready=0 and no mem_we. The write completes on the first disp_ena=0 cycle.
- Write with wr_col=50 -> wr_ready=1, mem_we=0, wr_err=1 and it stays 1 until rst.
- clear_req with disp_ena=0 throughout -> 1250 writes of value 0 to addresses 0..1249, busy=1 throughout, clear_done pulse on the cycle after the write to 1249, wr_ready=0 during the clear.
- Clear interrupted by disp_ena=1 for 10 cycles at address 600 -> those cycles are display reads and address 600 is written only after disp_ena falls. A rst during the clear -> busy=0 next cycle and no clear_done.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared geometry, pixel format, arbiter state type and the pixel-to-address
// mapping for the VGA frame-buffer slice.
package vga_pkg;

    localparam int unsigned H_PIXELS = 50;
    localparam int unsigned V_PIXELS = 25;
    localparam int unsigned H_BITS   = 7;
    localparam int unsigned V_BITS   = 5;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned FB_SIZE  = H_PIXELS * V_PIXELS;

    localparam logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(0);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FB_SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    // Row-major mapping; ADDR_W covers FB_SIZE, so in-range pixels never wrap.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [H_BITS-1:0] c,
                                                   input logic [V_BITS-1:0] r);
        return ADDR_W'(r) * ADDR_W'(H_PIXELS) + ADDR_W'(c);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-write request handshake between the drawing/host logic and the arbiter.
interface vga_fb_arbiter_if;
    import vga_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [H_BITS-1:0] wr_col;
    logic [V_BITS-1:0] wr_row;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, wr_col, wr_row, wr_data, input  wr_ready);
    modport slave  (input  wr_valid, wr_col, wr_row, wr_data, output wr_ready);

endinterface

// File: rtl/vga_fb_readpipe.sv
// Display read pipeline: RAM data arrives one cycle after the read and is
// registered, so a read issued in cycle t appears on pix_* in cycle t+2.
module vga_fb_readpipe
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data
);

    logic rd_q;

    // pix_data holds its last value between valid pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_q      <= rd_issue;
            pix_valid <= rd_q;
            if (rd_q) begin
                pix_data <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads win, then the hardware
// frame clear, then host pixel writes; writes only use blanking cycles.
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ena,
    input  logic [H_BITS-1:0] col,
    input  logic [V_BITS-1:0] row,
    vga_fb_arbiter_if.slave   wr,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data
);

    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              wr_err_q, wr_err_d;
    logic              clear_done_q, clear_done_d;
    logic              wr_in_range;

    assign wr_in_range = (wr.wr_col < H_BITS'(H_PIXELS)) && (wr.wr_row < V_BITS'(V_PIXELS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            wr_err_q     <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            wr_err_q     <= wr_err_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Port arbitration and next state; no write is issued while rst is held.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        wr_err_d     = wr_err_q;
        clear_done_d = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        wr.wr_ready  = 1'b0;

        if (disp_ena) begin
            mem_en   = 1'b1;
            mem_addr = pix_addr(col, row);
        end

        case (state_q)
            IDLE: begin
                wr.wr_ready = !disp_ena && !rst;
                if (wr.wr_valid && !disp_ena && !rst) begin
                    if (wr_in_range) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = pix_addr(wr.wr_col, wr.wr_row);
                        mem_wdata = wr.wr_data;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (!disp_ena && !rst) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = clr_addr_q;
                    mem_wdata = CLEAR_VALUE;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d      = IDLE;
                        clr_addr_d   = '0;
                        clear_done_d = 1'b1;
                    end else begin
                        clr_addr_d = clr_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == CLEAR);
    assign clear_done = clear_done_q;
    assign wr_err     = wr_err_q;

    vga_fb_readpipe u_readpipe (
        .clk       (clk),
        .rst       (rst),
        .rd_issue  (disp_ena),
        .mem_rdata (mem_rdata),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench: a frame-level reference model predicts every RAM access
// and status output; expected pixels are queued and matched by a monitor.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int N = int'(H_PIXELS * V_PIXELS);

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_ena;
    logic [H_BITS-1:0] col;
    logic [V_BITS-1:0] row;
    logic              clear_req;
    logic              busy, clear_done, wr_err;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;

    vga_fb_arbiter_if wr_bus ();

    vga_fb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .disp_ena   (disp_ena),
        .col        (col),
        .row        (row),
        .wr         (wr_bus),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .wr_err     (wr_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read-first, one-cycle read latency.
    logic [DATA_W-1:0] ram [0:2047];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int cyc;
    } pix_t;

    pix_t pq[$];
    int   ref_fb[N];
    bit   m_clear, m_err, m_done, last_acc;
    int   m_ptr;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: predict this cycle's behaviour from the frame model, compare, advance.
    task automatic step();
        bit e_en, e_we, e_rdy, n_done, n_err;
        int e_addr, e_wd, a;
        @(negedge clk);
        chk("busy", busy, 32'(m_clear));
        chk("clear_done", clear_done, 32'(m_done));
        chk("wr_err", wr_err, 32'(m_err));
        e_en = 0; e_we = 0; e_rdy = 0; e_addr = 0; e_wd = 0;
        n_done = 0; n_err = m_err;
        if (disp_ena) begin
            e_en   = 1;
            e_addr = int'(row) * int'(H_PIXELS) + int'(col);
            if (!rst) pq.push_back('{ref_fb[e_addr], cyc + 2});
        end
        if (rst) begin
            m_clear = 0;
            n_err   = 0;
            for (int i = pq.size() - 1; i >= 0; i--)
                if (pq[i].cyc > cyc) pq.delete(i);
        end else if (m_clear) begin
            if (!disp_ena) begin
                e_en = 1; e_we = 1; e_addr = m_ptr; e_wd = 0;
                ref_fb[m_ptr] = 0;
                m_ptr++;
                if (m_ptr == N) begin
                    m_clear = 0;
                    n_done  = 1;
                end
            end
        end else begin
            e_rdy = !disp_ena;
            if (wr_bus.wr_valid && e_rdy) begin
                if (int'(wr_bus.wr_col) < int'(H_PIXELS) && int'(wr_bus.wr_row) < int'(V_PIXELS)) begin
                    a = int'(wr_bus.wr_row) * int'(H_PIXELS) + int'(wr_bus.wr_col);
                    e_en = 1; e_we = 1; e_addr = a; e_wd = int'(wr_bus.wr_data);
                    ref_fb[a] = e_wd;
                end else begin
                    n_err = 1;
                end
            end
            if (clear_req) begin
                m_clear = 1;
                m_ptr   = 0;
            end
        end
        chk("wr_ready", wr_bus.wr_ready, 32'(e_rdy));
        chk("mem_en", mem_en, 32'(e_en));
        chk("mem_we", mem_we, 32'(e_we));
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        last_acc = wr_bus.wr_valid && e_rdy;
        m_done = n_done;
        m_err  = n_err;
        @(posedge clk);
        #1;
    endtask

    // Pixel monitor: each valid pixel must match the oldest expected read and its cycle.
    always @(negedge clk) begin : mon
        pix_t p;
        if (pix_valid === 1'b1) begin
            if (pq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL pix_unexpected: got data %0d expected no pixel (cycle %0d)", pix_data, cyc);
            end else begin
                p = pq.pop_front();
                chk("pix_data", pix_data, p.data);
                chk("pix_latency", cyc, p.cyc);
            end
        end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
            n_tests++; n_fail++;
            $display("FAIL pix_missing: got pix_valid=0 expected pixel %0d (cycle %0d)", pq[0].data, cyc);
            void'(pq.pop_front());
        end
    end

    task automatic idle_in();
        disp_ena = 0; col = '0; row = '0; clear_req = 0;
        wr_bus.wr_valid = 0;
    endtask

    task automatic read_px(input int c, input int r);
        disp_ena = 1; col = H_BITS'(c); row = V_BITS'(r);
        step();
        disp_ena = 0;
    endtask

    task automatic clear_rest();
        int guard = 0;
        while (m_clear && guard < 4000) begin
            step();
            guard++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = DATA_W'($urandom);
        ram[103] = 4'hA;
        for (int i = 0; i < N; i++) ref_fb[i] = int'(ram[i]);
        m_clear = 0; m_err = 0; m_done = 0; m_ptr = 0; last_acc = 0;
        idle_in();
        wr_bus.wr_col = '0; wr_bus.wr_row = '0; wr_bus.wr_data = '0;
        rst = 1;
        @(posedge clk); #1;
        step(); step();
        rst = 0;

        // Display read of (3,2) -> address 103, pixel 0xA two cycles later.
        read_px(3, 2);
        step(); step();

        // In-range host write at the last pixel.
        wr_bus.wr_valid = 1; wr_bus.wr_col = 7'd49; wr_bus.wr_row = 5'd24; wr_bus.wr_data = 4'd5;
        step();
        wr_bus.wr_valid = 0;

        // Write held across active display; completes on first blanking cycle.
        wr_bus.wr_valid = 1; wr_bus.wr_col = 7'd10; wr_bus.wr_row = 5'd3; wr_bus.wr_data = 4'd7;
        disp_ena = 1; col = 7'd1; row = 5'd1;
        repeat (3) step();
        disp_ena = 0;
        step();
        wr_bus.wr_valid = 0;
        read_px(10, 3);
        read_px(49, 24);
        step(); step();

        // Out-of-range write is accepted, dropped and flagged until reset.
        wr_bus.wr_valid = 1; wr_bus.wr_col = 7'd50; wr_bus.wr_row = 5'd0; wr_bus.wr_data = 4'd3;
        step();
        wr_bus.wr_valid = 0;
        repeat (3) step();

        // Full clear with no display activity.
        clear_req = 1; step(); clear_req = 0;
        clear_rest();
        repeat (2) step();
        read_px(3, 2);
        read_px(49, 24);
        step(); step();

        // Clear paused by 10 display cycles at address 600.
        clear_req = 1; step(); clear_req = 0;
        while (m_clear && m_ptr < 600) step();
        for (int i = 0; i < 10; i++) begin
            disp_ena = 1; col = H_BITS'($urandom_range(0, 49)); row = V_BITS'($urandom_range(0, 24));
            step();
        end
        disp_ena = 0;
        clear_rest();
        step();

        // Reset in the middle of a clear aborts it without clear_done.
        wr_bus.wr_valid = 1; wr_bus.wr_col = 7'd5; wr_bus.wr_row = 5'd5; wr_bus.wr_data = 4'd9;
        step();
        wr_bus.wr_valid = 0;
        clear_req = 1; step(); clear_req = 0;
        repeat (300) step();
        rst = 1; step(); rst = 0;
        repeat (3) step();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) disp_ena = !disp_ena;
            col = H_BITS'($urandom_range(0, 49));
            row = V_BITS'($urandom_range(0, 24));
            if (!wr_bus.wr_valid || last_acc) begin
                wr_bus.wr_valid = ($urandom_range(0, 1) == 1);
                wr_bus.wr_col   = H_BITS'($urandom_range(0, 55));
                wr_bus.wr_row   = V_BITS'($urandom_range(0, 26));
                wr_bus.wr_data  = DATA_W'($urandom);
            end
            clear_req = ($urandom_range(0, 599) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 0;
        idle_in();
        clear_rest();
        repeat (5) step();
        chk("pix_queue_drained", pq.size(), 0);
        for (int i = 0; i < N; i += 97) chk("ram_image", ram[i], ref_fb[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
